ov7670_pattern_gen: RTL and testbench

Synthetic OV7670 camera source: drives the same pclk/href/vsync/8-bit RGB565 byte stream that the camera presents to the capture-side memory controller. It replaces the sensor during bring-up and in simulation, so the capture → frame buffer → VGA path can be checked against known images. One instance sits where the camera pins would, muxed against the real sensor inputs at the display top level.

---
 rtl/ov7670_pattern_gen.sv | 186 ++++++++++++++++++
 tb/tb_ov7670_pattern_gen.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_pattern_gen.sv
// Synthetic OV7670 camera source: emits pclk/href/vsync and an RGB565 byte
// stream (high byte first) carrying one of four test patterns.
module ov7670_pattern_gen #(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] pattern_sel,
    output logic       pclk_o,
    output logic       href,
    output logic       vsync,
    output logic [7:0] data,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [15:0] L_M1   = 16'(2 * H_ACTIVE + H_BLANK - 1);
    localparam logic [15:0] HB2    = 16'(2 * H_ACTIVE);
    localparam logic [15:0] BAR_M1 = 16'(BAR_W - 1);
    localparam logic [15:0] VS_M1  = 16'(VSYNC_LINES - 1);
    localparam logic [15:0] VB_M1  = 16'(V_BACK - 1);
    localparam logic [15:0] VA_M1  = 16'(V_ACTIVE - 1);
    localparam logic [15:0] VF_M1  = 16'(V_FRONT - 1);

    logic        phase_q;
    state_t      state_q, state_d;
    logic [15:0] byte_q, byte_d;
    logic [15:0] line_q, line_d;
    logic [1:0]  pat_q, pat_d;
    logic [15:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic        href_q, href_d;
    logic        vsync_q, vsync_d;
    logic [7:0]  data_q, data_d;
    logic        frame_done_q, done_d;
    logic [15:0] lines_m1;
    logic [15:0] pixel;
    logic [8:0]  x;
    logic [4:0]  v;

    assign pclk_o     = phase_q;
    assign href       = href_q;
    assign vsync      = vsync_q;
    assign data       = data_q;
    assign frame_done = frame_done_q;

    // Next byte position and frame state, applied only at byte boundaries
    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        line_d   = line_q;
        pat_d    = pat_q;
        done_d   = 1'b0;
        lines_m1 = '0;
        case (state_q)
            S_VSYNC:  lines_m1 = VS_M1;
            S_VBACK:  lines_m1 = VB_M1;
            S_ACTIVE: lines_m1 = VA_M1;
            S_VFRONT: lines_m1 = VF_M1;
            default:  lines_m1 = '0;
        endcase
        if (state_q == S_IDLE) begin
            if (en) begin
                state_d = S_VSYNC;
                pat_d   = pattern_sel;
                byte_d  = '0;
                line_d  = '0;
            end
        end else if (byte_q == L_M1) begin
            byte_d = '0;
            if (line_q == lines_m1) begin
                line_d = '0;
                case (state_q)
                    S_VSYNC:  state_d = S_VBACK;
                    S_VBACK:  state_d = S_ACTIVE;
                    S_ACTIVE: state_d = S_VFRONT;
                    S_VFRONT: begin
                        done_d = 1'b1;
                        if (en) begin
                            state_d = S_VSYNC;
                            pat_d   = pattern_sel;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    default:  state_d = S_IDLE;
                endcase
            end else begin
                line_d = line_q + 16'd1;
            end
        end else begin
            byte_d = byte_q + 16'd1;
        end
    end

    // Bar index tracks the next byte's pixel by counting pixels, avoiding a divide
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (byte_d == 16'd0) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (!byte_d[0] && (byte_d != byte_q)) begin
            if (bar_cnt_q == BAR_M1) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + 16'd1;
            end
        end
    end

    // Pixel and output bytes for the byte that starts at this boundary
    always_comb begin
        x = byte_d[9:1];
        v = x[8:4];
        pixel = 16'h0000;
        case (pat_q)
            2'd0: begin
                case (bar_idx_d)
                    3'd0:    pixel = 16'hFFFF;
                    3'd1:    pixel = 16'hFFE0;
                    3'd2:    pixel = 16'h07FF;
                    3'd3:    pixel = 16'h07E0;
                    3'd4:    pixel = 16'hF81F;
                    3'd5:    pixel = 16'hF800;
                    3'd6:    pixel = 16'h001F;
                    default: pixel = 16'h0000;
                endcase
            end
            2'd1:    pixel = {v, v, 1'b0, v};
            2'd2:    pixel = (x[4] ^ line_d[4]) ? 16'hFFFF : 16'h0000;
            default: pixel = 16'hF800;
        endcase
        href_d  = (state_d == S_ACTIVE) && (byte_d < HB2);
        vsync_d = (state_d == S_VSYNC);
        data_d  = href_d ? (byte_d[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
    end

    // Phase free-runs; everything else registers only on the 1->0 phase edge
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q      <= 1'b0;
            state_q      <= S_IDLE;
            byte_q       <= '0;
            line_q       <= '0;
            pat_q        <= '0;
            bar_cnt_q    <= '0;
            bar_idx_q    <= '0;
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            data_q       <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            phase_q      <= ~phase_q;
            frame_done_q <= 1'b0;
            if (phase_q) begin
                state_q      <= state_d;
                byte_q       <= byte_d;
                line_q       <= line_d;
                pat_q        <= pat_d;
                bar_cnt_q    <= bar_cnt_d;
                bar_idx_q    <= bar_idx_d;
                href_q       <= href_d;
                vsync_q      <= vsync_d;
                data_q       <= data_d;
                frame_done_q <= done_d;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_pattern_gen.sv
// Bench for ov7670_pattern_gen: a small-geometry instance checked frame by
// frame against an arithmetic model, plus two default-geometry instances
// probed at specific pixels.
module tb_ov7670_pattern_gen;

    localparam int HA = 16, VA = 4, HB = 4, VS = 1, VB = 1, VF = 1;
    localparam int L  = 2 * HA + HB;
    localparam int NB = (VS + VB + VA + VF) * L;
    localparam int DL = 784;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en;
    logic [1:0] psel;
    logic       s_pclk, s_href, s_vs, s_fd;
    logic [7:0] s_data;

    logic       rst_d, en_d;
    logic [1:0] psel_c, psel_r;
    logic       c_pclk, c_href, c_vs, c_fd;
    logic [7:0] c_data;
    logic       r_pclk, r_href, r_vs, r_fd;
    logic [7:0] r_data;

    int total = 0;
    int bad   = 0;

    ov7670_pattern_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)) dut (
        .clk(clk), .reset(rst), .en(en), .pattern_sel(psel),
        .pclk_o(s_pclk), .href(s_href), .vsync(s_vs), .data(s_data), .frame_done(s_fd));

    ov7670_pattern_gen dut_c (
        .clk(clk), .reset(rst_d), .en(en_d), .pattern_sel(psel_c),
        .pclk_o(c_pclk), .href(c_href), .vsync(c_vs), .data(c_data), .frame_done(c_fd));

    ov7670_pattern_gen dut_r (
        .clk(clk), .reset(rst_d), .en(en_d), .pattern_sel(psel_r),
        .pclk_o(r_pclk), .href(r_href), .vsync(r_vs), .data(r_data), .frame_done(r_fd));

    // ---------------- reference model ----------------
    function automatic int pix(int p, int ha, int x, int y);
        int v;
        v = (x >> 4) & 31;
        case (p)
            0: begin
                case (x / (ha / 8))
                    0: return 'hFFFF;
                    1: return 'hFFE0;
                    2: return 'h07FF;
                    3: return 'h07E0;
                    4: return 'hF81F;
                    5: return 'hF800;
                    6: return 'h001F;
                    default: return 'h0000;
                endcase
            end
            1: return (v << 11) | (v << 6) | v;
            2: return (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 'hFFFF : 'h0000;
            default: return 'hF800;
        endcase
    endfunction

    function automatic logic [9:0] exp_byte(int p, int k);
        int line, b, px, d;
        logic vsb, hr;
        line = k / L;
        b    = k % L;
        vsb  = (line < VS);
        hr   = (line >= VS + VB) && (line < VS + VB + VA) && (b < 2 * HA);
        px   = pix(p, HA, b / 2, line - VS - VB);
        d    = hr ? (((b % 2 == 0) ? (px >> 8) : px) & 255) : 0;
        return {vsb, hr, d[7:0]};
    endfunction

    // ---------------- monitors ----------------
    int cyc = 0;
    always @(posedge clk) cyc++;

    int fd_cnt = 0;
    int fd_last = -1;
    int fd_q[$];
    always @(negedge clk) begin
        if (s_fd) begin
            fd_cnt++;
            if (fd_last >= 0) fd_q.push_back(cyc - fd_last);
            fd_last = cyc;
        end
    end

    function automatic int didx(int x, int y);
        return (3 + 17 + y) * DL + 2 * x;
    endfunction

    int kd = -1;
    logic pvs = 1'b0;
    logic [15:0] c00, c160, c1616, r319;
    always @(negedge clk) begin
        if (rst_d) begin
            kd = -1;
            pvs = 1'b0;
        end else if (c_pclk) begin
            if (c_vs && !pvs) kd = 0;
            else if (kd >= 0) kd++;
            pvs = c_vs;
            if (kd == didx(0, 0))       c00[15:8]   = c_data;
            if (kd == didx(0, 0) + 1)   c00[7:0]    = c_data;
            if (kd == didx(16, 0))      c160[15:8]  = c_data;
            if (kd == didx(16, 0) + 1)  c160[7:0]   = c_data;
            if (kd == didx(16, 16))     c1616[15:8] = c_data;
            if (kd == didx(16, 16) + 1) c1616[7:0]  = c_data;
            if (kd == didx(319, 0))     r319[15:8]  = r_data;
            if (kd == didx(319, 0) + 1) r319[7:0]   = r_data;
        end
    end

    // ---------------- capture helpers ----------------
    logic       cv [NB];
    logic       ch [NB];
    logic [7:0] cd [NB];
    int pre_href;

    task automatic next_byte();
        int n;
        n = 0;
        @(negedge clk);
        while (!s_pclk && n < 4) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Aligns to the first vsync byte, records one frame, and optionally
    // changes en/pattern_sel at byte act_k.
    task automatic capture_frame(input int act_k, input logic nen, input logic [1:0] np,
                                 output logic started);
        int n;
        n = 0;
        pre_href = 0;
        next_byte();
        while (!s_vs && n < 2000) begin
            if (s_href) pre_href++;
            next_byte();
            n++;
        end
        started = s_vs;
        for (int k = 0; k < NB; k++) begin
            if (k > 0) next_byte();
            if (k == act_k) begin
                en   = nen;
                psel = np;
            end
            cv[k] = s_vs;
            ch[k] = s_href;
            cd[k] = s_data;
        end
    endtask

    function automatic int frame_errs(int p, output int first, output logic [9:0] got,
                                      output logic [9:0] want);
        int errs;
        logic [9:0] e;
        errs = 0;
        first = -1;
        got = '0;
        want = '0;
        for (int k = 0; k < NB; k++) begin
            e = exp_byte(p, k);
            if ({cv[k], ch[k], cd[k]} !== e) begin
                if (first < 0) begin
                    first = k;
                    got = {cv[k], ch[k], cd[k]};
                    want = e;
                end
                errs++;
            end
        end
        return errs;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if ({s_pclk, s_href, s_vs, s_data, s_fd} !== 12'h000) begin
            bad++;
            $display("FAIL reset_values: got %h want 000", {s_pclk, s_href, s_vs, s_data, s_fd});
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if (s_pclk !== ((i % 2) == 0)) begin
                bad++;
                $display("FAIL idle_pclk cycle %0d: got %b want %b", i, s_pclk, (i % 2) == 0);
            end
            total++;
            if ({s_href, s_vs, s_data, s_fd} !== 11'h000) begin
                bad++;
                $display("FAIL idle_outputs cycle %0d: got %h want 000", i, {s_href, s_vs, s_data, s_fd});
            end
        end
    endtask

    task automatic test_frames();
        int pc, pn, errs, first, hp, len, gap, badp, both, vsn;
        logic st;
        logic [9:0] g, w;
        logic [15:0] px;
        logic [15:0] bars [16];
        bars = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0, 16'h07FF, 16'h07FF, 16'h07E0, 16'h07E0,
                 16'hF81F, 16'hF81F, 16'hF800, 16'hF800, 16'h001F, 16'h001F, 16'h0000, 16'h0000};
        psel = 2'd0;
        en = 1'b1;
        pc = 0;
        fd_last = -1;
        fd_q.delete();
        for (int f = 0; f < 4; f++) begin
            pn = int'($urandom_range(0, 3));
            capture_frame(5, 1'b1, 2'(pn), st);
            total++;
            if (st !== 1'b1) begin
                bad++;
                $display("FAIL frame%0d_start: vsync seen %b want 1", f, st);
            end
            errs = frame_errs(pc, first, g, w);
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL frame%0d_pattern%0d: %0d bytes differ, byte %0d got %h want %h",
                         f, pc, errs, first, g, w);
            end
            if (f == 0) begin
                vsn = 0; hp = 0; len = 0; gap = -1; badp = 0; both = 0;
                for (int k = 0; k < NB; k++) begin
                    if (cv[k]) vsn++;
                    if (cv[k] && ch[k]) both++;
                    if (ch[k]) begin
                        if (k == 0 || !ch[k-1]) begin
                            hp++;
                            if (gap >= 0 && gap != 4) badp++;
                            len = 0;
                        end
                        len++;
                        gap = 0;
                    end else begin
                        if (k > 0 && ch[k-1] && len != 32) badp++;
                        if (gap >= 0) gap++;
                    end
                end
                total++;
                if (vsn != 36) begin
                    bad++;
                    $display("FAIL vsync_bytes: got %0d want 36", vsn);
                end
                total++;
                if (hp != 4 || badp != 0) begin
                    bad++;
                    $display("FAIL href_pulses: got %0d pulses, %0d bad len/gap; want 4, 0", hp, badp);
                end
                total++;
                if (both != 0) begin
                    bad++;
                    $display("FAIL vsync_href_overlap: got %0d want 0", both);
                end
                for (int i = 0; i < 16; i++) begin
                    px = {cd[(VS + VB) * L + 2 * i], cd[(VS + VB) * L + 2 * i + 1]};
                    total++;
                    if (px !== bars[i]) begin
                        bad++;
                        $display("FAIL bar_pixel%0d: got %h want %h", i, px, bars[i]);
                    end
                end
            end
            pc = pn;
        end
        total++;
        if (fd_q.size() < 2) begin
            bad++;
            $display("FAIL frame_done_count: got %0d intervals want >=2", fd_q.size());
        end
        foreach (fd_q[i]) begin
            total++;
            if (fd_q[i] != 504) begin
                bad++;
                $display("FAIL frame_done_interval%0d: got %0d want 504", i, fd_q[i]);
            end
        end
        // one more frame with the randomly chosen pattern, queueing colour bars next
        capture_frame(5, 1'b1, 2'd0, st);
        errs = frame_errs(pc, first, g, w);
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL frame4_pattern%0d: %0d bytes differ, byte %0d got %h want %h",
                     pc, errs, first, g, w);
        end
    endtask

    task automatic test_en_drop();
        int errs, first, fd0, leak;
        logic st;
        logic [9:0] g, w;
        capture_frame((VS + VB + 1) * L + 3, 1'b0, 2'd3, st);
        errs = frame_errs(0, first, g, w);
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL en_drop_frame_bars: %0d bytes differ, byte %0d got %h want %h",
                     errs, first, g, w);
        end
        fd0 = fd_cnt;
        leak = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (s_vs || s_href || s_data != 8'h00) leak++;
        end
        total++;
        if (fd_cnt - fd0 != 1) begin
            bad++;
            $display("FAIL en_drop_frame_done: got %0d pulses want 1", fd_cnt - fd0);
        end
        total++;
        if (leak != 0) begin
            bad++;
            $display("FAIL en_drop_idle: got %0d active samples want 0", leak);
        end
        en = 1'b1;
        capture_frame(-1, 1'b1, 2'd3, st);
        errs = frame_errs(3, first, g, w);
        total++;
        if (errs != 0 || st !== 1'b1) begin
            bad++;
            $display("FAIL re_enable_solid_red: %0d bytes differ, byte %0d got %h want %h",
                     errs, first, g, w);
        end
    endtask

    task automatic test_reset_midline();
        int n, errs, first, fd0;
        logic st;
        logic [9:0] g, w;
        n = 0;
        @(negedge clk);
        while (!s_href && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (s_href !== 1'b1) begin
            bad++;
            $display("FAIL midline_href_seen: got %b want 1", s_href);
        end
        fd0 = fd_cnt;
        rst = 1'b1;
        psel = 2'd2;
        @(negedge clk);
        total++;
        if ({s_pclk, s_href, s_vs, s_data, s_fd} !== 12'h000) begin
            bad++;
            $display("FAIL midline_reset_outputs: got %h want 000",
                     {s_pclk, s_href, s_vs, s_data, s_fd});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        capture_frame(-1, 1'b1, 2'd2, st);
        total++;
        if (pre_href != 0 || st !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_vsync_first: got %0d early href bytes want 0", pre_href);
        end
        errs = frame_errs(2, first, g, w);
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL post_reset_frame: %0d bytes differ, byte %0d got %h want %h",
                     errs, first, g, w);
        end
        total++;
        if (fd_cnt != fd0) begin
            bad++;
            $display("FAIL reset_no_frame_done: got %0d pulses want 0", fd_cnt - fd0);
        end
    endtask

    task automatic test_checker_ramp();
        int n;
        n = 0;
        while (kd <= didx(16, 16) + 2 && n < 70000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (kd <= didx(16, 16) + 2) begin
            bad++;
            $display("FAIL default_timeout: byte index got %0d want >%0d", kd, didx(16, 16) + 2);
        end
        total++;
        if (c00 !== 16'h0000) begin
            bad++;
            $display("FAIL checker_0_0: got %h want 0000", c00);
        end
        total++;
        if (c160 !== 16'hFFFF) begin
            bad++;
            $display("FAIL checker_16_0: got %h want FFFF", c160);
        end
        total++;
        if (c1616 !== 16'h0000) begin
            bad++;
            $display("FAIL checker_16_16: got %h want 0000", c1616);
        end
        total++;
        if (r319 !== 16'h9CD3) begin
            bad++;
            $display("FAIL ramp_x319: got %h want 9CD3", r319);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; psel = 2'd0;
        rst_d = 1'b1; en_d = 1'b0; psel_c = 2'd2; psel_r = 2'd1;
        c00 = 16'hxxxx; c160 = 16'hxxxx; c1616 = 16'hxxxx; r319 = 16'hxxxx;
        test_reset();
        rst_d = 1'b0;
        en_d  = 1'b1;
        test_frames();
        test_en_drop();
        test_reset_midline();
        test_checker_ramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
